// File: rtl/full_sub_pkg.sv
// Shared constants for the 4-bit ripple-borrow subtractor.
// Holds the datapath width and the output reset values.
package full_sub_pkg;

    localparam int SUB_W = 4;

    localparam logic [SUB_W-1:0] DIFF_RST = '0;
    localparam logic             COUT_RST = 1'b0;

endpackage

// File: rtl/full_sub_1bit.sv
// Single full-subtractor cell: d = x - y - bin, bout is borrow-out.
// Purely combinational; chained LSB to MSB by full_sub_4bit.
module full_sub_1bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/full_sub_4bit.sv
// 4-bit ripple-borrow subtractor with registered diff/cout/out_valid.
// Define FULL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module full_sub_4bit
    import full_sub_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [SUB_W-1:0] x,
    input  logic [SUB_W-1:0] y,
    input  logic             cin,
    output logic [SUB_W-1:0] diff,
    output logic             cout,
    output logic             out_valid
`ifdef FULL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    logic [SUB_W:0]   b;
    logic [SUB_W-1:0] diff_next;

    assign b[0] = cin;

    for (genvar i = 0; i < SUB_W; i++) begin : g_cell
        full_sub_1bit u_cell (
            .x    (x[i]),
            .y    (y[i]),
            .bin  (b[i]),
            .d    (diff_next[i]),
            .bout (b[i+1])
        );
    end

`ifdef FULL_SUB_OVF_EN
    logic ovf_next;

    // Operands of differing sign whose result sign flips away from x.
    assign ovf_next = (x[SUB_W-1] ^ y[SUB_W-1])
                    & (diff_next[SUB_W-1] ^ x[SUB_W-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (in_valid) begin
            ovf <= ovf_next;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff      <= DIFF_RST;
            cout      <= COUT_RST;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                diff <= diff_next;
                cout <= b[SUB_W];
            end
        end
    end

endmodule

// File: tb/tb_full_sub_4bit.sv
// Directed and exhaustive checks for full_sub_4bit.
// Build with +define+FULL_SUB_OVF_EN to also check ovf.
module tb_full_sub_4bit;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] x;
    logic [3:0] y;
    logic       cin;
    logic [3:0] diff;
    logic       cout;
    logic       out_valid;
`ifdef FULL_SUB_OVF_EN
    logic       ovf;
`endif

    int checks;
    int failures;

    full_sub_4bit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .x         (x),
        .y         (y),
        .cin       (cin),
        .diff      (diff),
        .cout      (cout),
        .out_valid (out_valid)
`ifdef FULL_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] xa, input logic [3:0] ya,
                         input logic ca, input logic va);
        x        = xa;
        y        = ya;
        cin      = ca;
        in_valid = va;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        in_valid = 1'b1;
        x        = 4'd5;
        y        = 4'd3;
        cin      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (diff !== 4'd0 || cout !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_init: got diff=%0d cout=%b vld=%b want 0 0 0",
                     diff, cout, out_valid);
        end
`ifdef FULL_SUB_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_ovf: got %b want 0", ovf);
        end
`endif
        rst = 1'b0;
        drive(4'd3, 4'd5, 1'b0, 1'b1);
        checks++;
        if (diff !== 4'd14 || cout !== 1'b1 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_op: got diff=%0d cout=%b vld=%b want 14 1 1",
                     diff, cout, out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (diff !== 4'd0 || cout !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got diff=%0d cout=%b vld=%b want 0 0 0",
                     diff, cout, out_valid);
        end
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        drive(4'd5, 4'd3, 1'b0, 1'b1);
        checks++;
        if (diff !== 4'd2 || cout !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL basic_5_3: got diff=%0d cout=%b vld=%b want 2 0 1",
                     diff, cout, out_valid);
        end
    endtask

    task automatic test_borrow_chain;
        drive(4'd0, 4'd0, 1'b1, 1'b1);
        checks++;
        if (diff !== 4'd15 || cout !== 1'b1) begin
            failures++;
            $display("FAIL borrow_0_0_1: got diff=%0d cout=%b want 15 1",
                     diff, cout);
        end
        drive(4'd3, 4'd5, 1'b0, 1'b1);
        checks++;
        if (diff !== 4'd14 || cout !== 1'b1) begin
            failures++;
            $display("FAIL borrow_3_5_0: got diff=%0d cout=%b want 14 1",
                     diff, cout);
        end
        drive(4'd15, 4'd15, 1'b1, 1'b1);
        checks++;
        if (diff !== 4'd15 || cout !== 1'b1) begin
            failures++;
            $display("FAIL borrow_15_15_1: got diff=%0d cout=%b want 15 1",
                     diff, cout);
        end
    endtask

    task automatic test_hold;
        drive(4'd9, 4'd4, 1'b1, 1'b1);
        checks++;
        if (diff !== 4'd4 || cout !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL hold_load: got diff=%0d cout=%b vld=%b want 4 0 1",
                     diff, cout, out_valid);
        end
        drive(4'd1, 4'd2, 1'b0, 1'b0);
        checks++;
        if (diff !== 4'd4 || cout !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_idle: got diff=%0d cout=%b vld=%b want 4 0 0",
                     diff, cout, out_valid);
        end
        drive(4'd1, 4'd2, 1'b0, 1'b0);
        checks++;
        if (diff !== 4'd4 || cout !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_idle2: got diff=%0d cout=%b vld=%b want 4 0 0",
                     diff, cout, out_valid);
        end
    endtask

    task automatic test_reset_wins;
        rst = 1'b1;
        drive(4'd7, 4'd2, 1'b0, 1'b1);
        checks++;
        if (diff !== 4'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_wins: got diff=%0d vld=%b want 0 0",
                     diff, out_valid);
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [8:0] v;
        logic [4:0] r;
        int         s;
        for (int i = 0; i < 512; i++) begin
            v = 9'(i);
            drive(v[8:5], v[4:1], v[0], 1'b1);
            r = {1'b0, v[8:5]} - {1'b0, v[4:1]} - {4'd0, v[0]};
            checks++;
            if (diff !== r[3:0] || cout !== r[4] || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL sweep_%0d: got diff=%0d cout=%b vld=%b want %0d %b 1",
                         i, diff, cout, out_valid, r[3:0], r[4]);
            end
`ifdef FULL_SUB_OVF_EN
            s = int'($signed(v[8:5])) - int'($signed(v[4:1])) - int'(v[0]);
            checks++;
            if (ovf !== ((s > 7) || (s < -8))) begin
                failures++;
                $display("FAIL sweep_ovf_%0d: got %b want %b",
                         i, ovf, ((s > 7) || (s < -8)));
            end
`else
            s = 0;
`endif
        end
        in_valid = 1'b0;
    endtask

`ifdef FULL_SUB_OVF_EN
    task automatic test_ovf;
        drive(4'd8, 4'd1, 1'b0, 1'b1);
        checks++;
        if (diff !== 4'd7 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_8_1: got diff=%0d ovf=%b want 7 1", diff, ovf);
        end
        drive(4'd7, 4'd1, 1'b0, 1'b1);
        checks++;
        if (diff !== 4'd6 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_7_1: got diff=%0d ovf=%b want 6 0", diff, ovf);
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_borrow_chain();
        test_hold();
        test_reset_wins();
        test_back_to_back();
`ifdef FULL_SUB_OVF_EN
        test_ovf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/full_sub_4bit.md
# full_sub_4bit

4-bit ripple-borrow full subtractor with registered outputs, used as the subtraction primitive in the arithmetic lab datapath. It computes x − y − cin, producing a 4-bit difference and a borrow-out. Inputs are sampled on a clock edge and results are presented one cycle later with a valid strobe.

## Interface
Parameters: none; width fixed at 4.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high
- in_valid  input  1  x/y/cin are valid this cycle
- x  input  4  minuend, unsigned
- y  input  4  subtrahend, unsigned
- cin  input  1  borrow-in
- diff  output  4  registered difference
- cout  output  1  registered borrow-out
- out_valid  output  1  diff/cout hold a fresh result
- ovf  output  1  registered two's-complement overflow; present only with FULL_SUB_OVF_EN

Clocking: one clock, clk. Reset: rst is asynchronous and active-high.

## Operation
- Combinational core: four 1-bit full-subtractor cells chained LSB to MSB. Cell i: d_i = x_i ^ y_i ^ b_i; b_{i+1} = (~x_i & y_i) | (~(x_i ^ y_i) & b_i); b_0 = cin.
- Arithmetic result: {cout, diff} = {1'b0, x} − {1'b0, y} − cin, in 5-bit two's complement.
- cout = 1 exactly when x < y + cin, read as unsigned values.
- diff = (x − y − cin) mod 16.
- All 512 input combinations are legal. No X propagation when inputs are known.
- When in_valid = 1 at a clk edge, diff, cout (and ovf) load the new result, and out_valid is set to 1.
- When in_valid = 0 at a clk edge, diff, cout (and ovf) hold their previous values, and out_valid is set to 0.

## Timing
- Latency: 1 cycle. A result sampled at edge N is visible after edge N.
- Throughput: one operation per cycle. Back-to-back in_valid is allowed. There is no backpressure.
- Reset values: diff = 4'b0000, cout = 0, out_valid = 0, ovf = 0.
- Reset applies immediately on rst assertion, with no clock needed. It overrides any in-flight result.
- The first edge with rst low and in_valid = 1 produces a valid result on the next cycle.
- in_valid and rst both high: reset wins.

## Configuration
- FULL_SUB_OVF_EN defined:
  - Adds the ovf output.
  - ovf = (x[3] ^ y[3]) & (diff_next[3] ^ x[3]), which is signed overflow of x − y − cin.
  - ovf is registered alongside diff and has the same reset and hold rules.
- FULL_SUB_OVF_EN undefined:
  - The ovf port and its logic are absent.
  - All other behaviour is identical.

## Structure
- Shared package full_sub_pkg holds:
  - localparam SUB_W = 4;
  - the reset-value constants (diff 0, cout 0).
- One sub-module: full_sub_1bit. Its ports are x, y, bin, d, bout, and it is purely combinational.
- Instantiate four full_sub_1bit cells in a generate loop.
- The output register stage lives in the top module.

## Test plan
- Reset: assert rst asynchronously mid-cycle after a valid op → diff = 0, cout = 0, out_valid = 0 immediately, with no clock edge needed.
- Basic: x = 5, y = 3, cin = 0 → next cycle diff = 2, cout = 0, out_valid = 1.
- Borrow chain:
  - x = 0, y = 0, cin = 1 → diff = 15, cout = 1.
  - x = 3, y = 5, cin = 0 → diff = 14, cout = 1.
  - x = 15, y = 15, cin = 1 → diff = 15, cout = 1.
- Hold: valid op x = 9, y = 4, cin = 1 (diff = 4), then in_valid = 0 with x = 1, y = 2 → diff stays 4, cout stays 0, out_valid = 0.
- Exhaustive: sweep {x, y, cin} = 0…511 with in_valid = 1 every cycle → each result matches the 5-bit reference x − y − cin one cycle later, with no gaps in out_valid.
- Overflow (FULL_SUB_OVF_EN only):
  - x = 8, y = 1, cin = 0 → diff = 7, ovf = 1.
  - x = 7, y = 1, cin = 0 → diff = 6, ovf = 0.
